// File: rtl/hydra_pkg.sv
// Shared types and widths for the hydra egress receiver.
package hydra_pkg;

   localparam int unsigned PORT_NUM = 16;
   localparam int unsigned LEN_W    = 9;
   localparam int unsigned PRIO_W   = 3;
   localparam int unsigned DEST_W   = $clog2(PORT_NUM);
   localparam int unsigned CNT_W    = LEN_W + 1;
   localparam int unsigned DATA_W   = LEN_W + PRIO_W + DEST_W;

   // Header word: [15:7] length, [6:4] priority, [3:0] destination
   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [PRIO_W-1:0] prio;
      logic [DEST_W-1:0] dest;
   } hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_SOP,
      ST_HDR,
      ST_DATA,
      ST_DONE
   } state_t;

endpackage

// File: rtl/hydra_rx_watchdog.sv
// Loadable down-counter watchdog; expired_o is registered and holds until the next clear.
module hydra_rx_watchdog #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         start_i,
   input  logic [W-1:0] load_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;
   logic         expired_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q     <= load_i;
         expired_q <= (load_i == '0);
      end else if (start_i && !expired_q) begin
         cnt_q     <= cnt_q - W'(1);
         expired_q <= (cnt_q == W'(1));
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/hydra_port_rx.sv
// Egress packet receiver for one hydra output port: requests, parses and checks packets.
// Optional payload pattern checker is built when HYDRA_RX_PATTERN_CHK_EN is defined.
module hydra_port_rx
   import hydra_pkg::*;
#(
   parameter int unsigned PORT_ID  = 0,
   parameter int unsigned TIMEOUT  = 1024,
   parameter bit          AUTO_REQ = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              req_go,
   output logic              ready,
   input  logic              rd_sop,
   input  logic              rd_vld,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_eop,
   output logic              pkt_done,
   output logic [LEN_W-1:0]  pkt_len,
   output logic [PRIO_W-1:0] pkt_prio,
   output logic [DEST_W-1:0] pkt_dest,
   output logic              err_len,
   output logic              err_dest,
   output logic              err_proto,
   output logic              err_timeout,
   output logic [15:0]       pkt_cnt,
   output logic [31:0]       word_cnt,
   output logic [15:0]       err_cnt
`ifdef HYDRA_RX_PATTERN_CHK_EN
   ,
   output logic              err_data,
   output logic [CNT_W-1:0]  first_bad_idx
`endif
);

   localparam int unsigned WD_W = 16;
   // Loaded on leaving REQ so expiry lands exactly TIMEOUT cycles after ready rises
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 2) ? (TIMEOUT - 2) : 0);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   hdr_t             hdr_w;
   logic             close_c;
   logic             len_bad_c;
   logic             dest_bad_c;
   logic             data_bad_c;
   logic             wd_clr;
   logic             wd_start;
   logic             wd_expired;

   assign wd_clr   = (state_q == ST_REQ);
   assign wd_start = (state_q == ST_WAIT_SOP);

   hydra_rx_watchdog #(.W(WD_W)) u_wd (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .start_i   (wd_start),
      .load_i    (WD_LOAD),
      .expired_o (wd_expired)
   );

   // Packet close detection and per-packet error evaluation (word on eop counts first)
   always_comb begin
      hdr_w      = hdr_t'(rd_data);
      cnt_d      = cnt_q;
      close_c    = 1'b0;
      len_bad_c  = 1'b0;
      dest_bad_c = 1'b0;
      if (rd_vld && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (!rd_sop && rd_eop) begin
         if (state_q == ST_HDR) begin
            close_c    = 1'b1;
            len_bad_c  = rd_vld ? (hdr_w.len != '0) : 1'b1;
            dest_bad_c = rd_vld && (hdr_w.dest != DEST_W'(PORT_ID));
         end else if (state_q == ST_DATA) begin
            close_c    = 1'b1;
            len_bad_c  = (cnt_d != CNT_W'(pkt_len));
            dest_bad_c = (pkt_dest != DEST_W'(PORT_ID));
         end
      end
   end

`ifdef HYDRA_RX_PATTERN_CHK_EN
   logic             word_bad_c;
   logic [CNT_W-1:0] first_bad_c;
   logic             bad_seen_q;
   logic [CNT_W-1:0] bad_idx_q;

   // Payload word i must carry i
   always_comb begin
      word_bad_c  = (state_q == ST_DATA) && rd_vld && (rd_data != DATA_W'(cnt_q));
      data_bad_c  = 1'b0;
      first_bad_c = '0;
      if (state_q == ST_DATA) begin
         data_bad_c  = bad_seen_q || word_bad_c;
         first_bad_c = bad_seen_q ? bad_idx_q : (word_bad_c ? cnt_q : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bad_seen_q    <= 1'b0;
         bad_idx_q     <= '0;
         err_data      <= 1'b0;
         first_bad_idx <= '0;
      end else begin
         err_data <= close_c && data_bad_c;
         if (close_c) first_bad_idx <= first_bad_c;
         if ((state_q == ST_HDR) && rd_vld && !rd_sop) begin
            bad_seen_q <= 1'b0;
         end else if (word_bad_c && !rd_sop && !bad_seen_q) begin
            bad_seen_q <= 1'b1;
            bad_idx_q  <= cnt_q;
         end
      end
   end
`else
   assign data_bad_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ready       <= 1'b0;
         pkt_done    <= 1'b0;
         pkt_len     <= '0;
         pkt_prio    <= '0;
         pkt_dest    <= '0;
         err_len     <= 1'b0;
         err_dest    <= 1'b0;
         err_proto   <= 1'b0;
         err_timeout <= 1'b0;
         pkt_cnt     <= '0;
         word_cnt    <= '0;
         err_cnt     <= '0;
      end else begin
         ready    <= 1'b0;
         pkt_done <= 1'b0;
         err_len  <= 1'b0;
         err_dest <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rd_vld) err_proto <= 1'b1;
               if (enable && (AUTO_REQ || req_go)) begin
                  state_q <= ST_REQ;
                  ready   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (rd_vld) err_proto <= 1'b1;
               state_q <= ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
               if (rd_vld) err_proto <= 1'b1;
               if (rd_sop) begin
                  state_q <= ST_HDR;
               end else if (wd_expired) begin
                  err_timeout <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_HDR: begin
               if (rd_sop) begin
                  err_proto <= 1'b1;
               end else if (rd_vld) begin
                  pkt_len  <= hdr_w.len;
                  pkt_prio <= hdr_w.prio;
                  pkt_dest <= hdr_w.dest;
                  cnt_q    <= '0;
                  state_q  <= rd_eop ? ST_DONE : ST_DATA;
               end else if (rd_eop) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DATA: begin
               if (rd_sop) begin
                  err_proto <= 1'b1;
                  state_q   <= ST_HDR;
               end else begin
                  if (rd_vld) begin
                     cnt_q    <= cnt_d;
                     word_cnt <= word_cnt + 32'd1;
                  end
                  if (rd_eop) state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         // Results and counters publish on the edge that samples eop
         if (close_c) begin
            pkt_done <= 1'b1;
            err_len  <= len_bad_c;
            err_dest <= dest_bad_c;
            pkt_cnt  <= pkt_cnt + 16'd1;
            if ((len_bad_c || dest_bad_c || data_bad_c) && (err_cnt != 16'hFFFF))
               err_cnt <= err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hydra_port_rx.sv
// Directed self-checking bench for hydra_port_rx (PORT_ID=3, TIMEOUT=16, AUTO_REQ=0).
module tb_hydra_port_rx;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        req_go;
   logic        ready;
   logic        rd_sop;
   logic        rd_vld;
   logic [15:0] rd_data;
   logic        rd_eop;
   logic        pkt_done;
   logic [8:0]  pkt_len;
   logic [2:0]  pkt_prio;
   logic [3:0]  pkt_dest;
   logic        err_len;
   logic        err_dest;
   logic        err_proto;
   logic        err_timeout;
   logic [15:0] pkt_cnt;
   logic [31:0] word_cnt;
   logic [15:0] err_cnt;
`ifdef HYDRA_RX_PATTERN_CHK_EN
   logic        err_data;
   logic [9:0]  first_bad_idx;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int done_ref;

   hydra_port_rx #(.PORT_ID(3), .TIMEOUT(16), .AUTO_REQ(1'b0)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .req_go      (req_go),
      .ready       (ready),
      .rd_sop      (rd_sop),
      .rd_vld      (rd_vld),
      .rd_data     (rd_data),
      .rd_eop      (rd_eop),
      .pkt_done    (pkt_done),
      .pkt_len     (pkt_len),
      .pkt_prio    (pkt_prio),
      .pkt_dest    (pkt_dest),
      .err_len     (err_len),
      .err_dest    (err_dest),
      .err_proto   (err_proto),
      .err_timeout (err_timeout),
      .pkt_cnt     (pkt_cnt),
      .word_cnt    (word_cnt),
      .err_cnt     (err_cnt)
`ifdef HYDRA_RX_PATTERN_CHK_EN
      ,
      .err_data      (err_data),
      .first_bad_idx (first_bad_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (pkt_done) n_done++;

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish, required finish before 100000ns");
      $fatal(1, "bench timed out");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic sop, input logic vld, input logic eop, input logic [15:0] d);
      rd_sop  = sop;
      rd_vld  = vld;
      rd_eop  = eop;
      rd_data = d;
      cyc();
   endtask

   task automatic req_pkt(input string tag);
      enable = 1'b1;
      req_go = 1'b1;
      cyc();
      chk({tag, "_ready_hi"}, 32'(ready), 32'd1);
      req_go = 1'b0;
      cyc();
      chk({tag, "_ready_lo"}, 32'(ready), 32'd0);
   endtask

   // sop, header, nw payload words (word i = i, except bad_idx), eop on last word
   task automatic send_pkt(input int len, input int prio, input int dest, input int nw, input int bad_idx);
      logic [15:0] h;
      h = {9'(len), 3'(prio), 4'(dest)};
      drv(1'b1, 1'b0, 1'b0, 16'h0);
      drv(1'b0, 1'b1, 1'b0, h);
      if (nw == 0) drv(1'b0, 1'b0, 1'b1, 16'h0);
      for (int i = 0; i < nw; i++)
         drv(1'b0, 1'b1, (i == nw - 1), (i == bad_idx) ? 16'hBEEF : 16'(i));
      rd_vld  = 1'b0;
      rd_eop  = 1'b0;
      rd_data = 16'h0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; req_go = 1'b0;
      rd_sop = 1'b0; rd_vld = 1'b0; rd_eop = 1'b0; rd_data = 16'h0;
      cyc(); cyc();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_pkt_done", 32'(pkt_done), 32'd0);
      chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      chk("rst_word_cnt", word_cnt, 32'd0);
      chk("rst_err_flags", 32'({err_len, err_dest, err_proto, err_timeout}), 32'd0);
      rst = 1'b0;
      cyc();
      chk("idle_no_req", 32'(ready), 32'd0);

      // good packet
      req_pkt("t1");
      send_pkt(31, 4, 3, 31, -1);
      chk("t1_done", 32'(pkt_done), 32'd1);
      chk("t1_len", 32'(pkt_len), 32'd31);
      chk("t1_prio", 32'(pkt_prio), 32'd4);
      chk("t1_dest", 32'(pkt_dest), 32'd3);
      chk("t1_errs", 32'({err_len, err_dest}), 32'd0);
      chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("t1_word_cnt", word_cnt, 32'd31);
      chk("t1_err_cnt", 32'(err_cnt), 32'd0);
`ifdef HYDRA_RX_PATTERN_CHK_EN
      chk("t1_err_data", 32'(err_data), 32'd0);
`endif
      cyc();
      chk("t1_done_pulse", 32'(pkt_done), 32'd0);
      chk("t1_no_autoreq", 32'(ready), 32'd0);

      // short by one word
      req_pkt("t2");
      send_pkt(55, 0, 3, 54, -1);
      chk("t2_done", 32'(pkt_done), 32'd1);
      chk("t2_err_len", 32'(err_len), 32'd1);
      chk("t2_err_dest", 32'(err_dest), 32'd0);
      chk("t2_err_cnt", 32'(err_cnt), 32'd1);
      chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);
      chk("t2_word_cnt", word_cnt, 32'd85);
      cyc();
      chk("t2_err_len_pulse", 32'(err_len), 32'd0);

      // wrong destination, enable dropped mid-packet
      req_pkt("t3");
      enable = 1'b0;
      send_pkt(2, 1, 5, 2, -1);
      chk("t3_done", 32'(pkt_done), 32'd1);
      chk("t3_err_dest", 32'(err_dest), 32'd1);
      chk("t3_err_len", 32'(err_len), 32'd0);
      chk("t3_dest", 32'(pkt_dest), 32'd5);
      chk("t3_err_cnt", 32'(err_cnt), 32'd2);
      req_go = 1'b1;
      cyc(); cyc(); cyc();
      chk("t3_disabled_no_req", 32'(ready), 32'd0);
      req_go = 1'b0;

      // zero-length packet
      req_pkt("t4");
      send_pkt(0, 7, 3, 0, -1);
      chk("t4_done", 32'(pkt_done), 32'd1);
      chk("t4_errs", 32'({err_len, err_dest}), 32'd0);
      chk("t4_len", 32'(pkt_len), 32'd0);
      chk("t4_prio", 32'(pkt_prio), 32'd7);
      chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd4);
      chk("t4_word_cnt", word_cnt, 32'd87);
      cyc();

      // request timeout: err_timeout rises exactly 16 cycles after ready
      req_pkt("t5");
      for (int i = 0; i < 14; i++) cyc();
      chk("t5_timeout_early", 32'(err_timeout), 32'd0);
      cyc();
      chk("t5_timeout", 32'(err_timeout), 32'd1);
      req_pkt("t5b");
      chk("t5_sticky", 32'(err_timeout), 32'd1);
      send_pkt(4, 0, 3, 4, -1);
      chk("t5_done", 32'(pkt_done), 32'd1);
      chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd5);
      cyc();

      // sop mid-packet drops the partial packet
      done_ref = n_done;
      req_pkt("t6");
      chk("t6_proto_clean", 32'(err_proto), 32'd0);
      drv(1'b1, 1'b0, 1'b0, 16'h0);
      drv(1'b0, 1'b1, 1'b0, {9'd20, 3'd0, 4'd3});
      for (int i = 0; i < 10; i++) drv(1'b0, 1'b1, 1'b0, 16'(i));
      send_pkt(4, 2, 3, 4, -1);
      chk("t6_done", 32'(pkt_done), 32'd1);
      chk("t6_len", 32'(pkt_len), 32'd4);
      chk("t6_prio", 32'(pkt_prio), 32'd2);
      chk("t6_err_len", 32'(err_len), 32'd0);
      chk("t6_err_proto", 32'(err_proto), 32'd1);
      chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd6);
      chk("t6_word_cnt", word_cnt, 32'd105);
      cyc();
      chk("t6_one_done", 32'(n_done - done_ref), 32'd1);
      chk("t6_proto_sticky", 32'(err_proto), 32'd1);

`ifdef HYDRA_RX_PATTERN_CHK_EN
      // corrupted payload word 7
      req_pkt("t7");
      send_pkt(128, 0, 3, 128, 7);
      chk("t7_err_data", 32'(err_data), 32'd1);
      chk("t7_first_bad", 32'(first_bad_idx), 32'd7);
      chk("t7_err_len", 32'(err_len), 32'd0);
      chk("t7_err_cnt", 32'(err_cnt), 32'd3);
      cyc();
`endif

      // reset mid-packet
      req_pkt("t8");
      drv(1'b1, 1'b0, 1'b0, 16'h0);
      drv(1'b0, 1'b1, 1'b0, {9'd8, 3'd1, 4'd3});
      for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 1'b0, 16'(i));
      rd_vld = 1'b0;
      rst    = 1'b1;
      cyc();
      chk("t8_rst_ready", 32'(ready), 32'd0);
      chk("t8_rst_hdr", 32'({pkt_len, pkt_prio, pkt_dest}), 32'd0);
      chk("t8_rst_flags", 32'({pkt_done, err_len, err_dest, err_proto, err_timeout}), 32'd0);
      chk("t8_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      chk("t8_rst_word_cnt", word_cnt, 32'd0);
      chk("t8_rst_err_cnt", 32'(err_cnt), 32'd0);
`ifdef HYDRA_RX_PATTERN_CHK_EN
      chk("t8_rst_pat", 32'({err_data, first_bad_idx}), 32'd0);
`endif
      rst = 1'b0;
      cyc();

      // stray data word while idle
      drv(1'b0, 1'b1, 1'b0, 16'h1234);
      rd_vld = 1'b0;
      chk("t9_stray_proto", 32'(err_proto), 32'd1);
      chk("t9_stray_word_cnt", word_cnt, 32'd0);

      // recovery after reset
      req_pkt("t10");
      send_pkt(3, 0, 3, 3, -1);
      chk("t10_done", 32'(pkt_done), 32'd1);
      chk("t10_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("t10_word_cnt", word_cnt, 32'd3);
      chk("t10_err_cnt", 32'(err_cnt), 32'd0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hydra_port_rx.md
# hydra_port_rx

Egress-side packet receiver for one hydra output port. Requests a packet from the switch with a single-cycle `ready` pulse, then consumes the `rd_sop` / `rd_vld` / `rd_data` / `rd_eop` stream. Parses the header word, counts payload words and checks length and destination. Publishes per-packet results and running statistics. One instance sits on each of the 16 output ports in bench and board-level harnesses.

## Interface
- `PORT_ID`, 0: this port's index (0..15), compared against header dest field
- `TIMEOUT`, 1024: cycles to wait for `rd_sop` after a request before aborting
- `AUTO_REQ`, 1: 1 = re-request automatically after each packet; 0 = request only on `req_go`
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `enable`  in  1  block may issue requests while high
- `req_go`  in  1  single request trigger, used when `AUTO_REQ`=0
- `ready`  out  1  registered request pulse to switch
- `rd_sop`  in  1  start of packet
- `rd_vld`  in  1  data word valid
- `rd_data`  in  16  data word
- `rd_eop`  in  1  end of packet
- `pkt_done`  out  1  one-cycle pulse, packet result valid
- `pkt_len`  out  9  header length field of the last packet
- `pkt_prio`  out  3  header priority field
- `pkt_dest`  out  4  header destination field
- `err_len`  out  1  received payload count differed from `pkt_len` (valid with `pkt_done`)
- `err_dest`  out  1  `pkt_dest` != `PORT_ID`
- `err_proto`  out  1  sticky: `rd_sop` mid-packet, or `rd_vld` outside a packet
- `err_timeout`  out  1  sticky: request timed out
- `pkt_cnt`  out  16  packets completed, wraps
- `word_cnt`  out  32  payload words received, wraps
- `err_cnt`  out  16  packets with any error, saturates at 16'hFFFF

## Operation
- Header word layout: [15:7] length (payload words, 0..511), [6:4] priority, [3:0] dest.
- FSM states and transitions:
  - IDLE: go to REQ when `enable` and (`AUTO_REQ` or `req_go`).
  - REQ: `ready`=1 for exactly this one cycle; clear watchdog; go to WAIT_SOP.
  - WAIT_SOP: on `rd_sop` go to HDR; when watchdog reaches `TIMEOUT`, set `err_timeout` and go to IDLE.
  - HDR: the first `rd_vld` word latches header fields; clear the payload counter; go to DATA. `rd_eop` before any header sets `err_len` and goes to DONE.
  - DATA: each `rd_vld` increments the payload counter and `word_cnt`. On `rd_eop` go to DONE.
  - DONE: pulse `pkt_done`; evaluate `err_len` and `err_dest`; `pkt_cnt`++; `err_cnt`++ if any per-packet error; go to IDLE.
- `rd_eop` together with `rd_vld`: the word is counted first, then the packet closes.
- `rd_sop` in HDR or DATA: set `err_proto`, drop the partial packet (no `pkt_done`), restart at HDR.
- `rd_vld` in IDLE, REQ or WAIT_SOP: set `err_proto` and ignore the word.
- Payload counter is 10 bits, so 512+ words cannot alias a valid length; it saturates at 1023.
- Length 0 is legal: header followed by `rd_eop`.
- `enable` deasserted mid-packet: the packet completes; no new request is issued.
- Sticky flags clear only on `rst`.

## Timing
- All outputs are registered.
- Reset values: every output is 0; FSM is in IDLE.
- `rst` mid-packet: state returns to IDLE on the next edge; counters are zeroed.
- Request latency: `ready` rises 1 cycle after IDLE sees its trigger (the cycle REQ is entered registers `ready` high).
- Result latency: `pkt_done`, `err_len` and `err_dest` are high the cycle after `rd_eop` is sampled. `pkt_len`, `pkt_prio` and `pkt_dest` hold until the next header.
- Counters update on the same cycle as `pkt_done`; `word_cnt` updates per word.
- With `AUTO_REQ`=1 the minimum gap from `rd_eop` to the next `ready` is 3 cycles (DONE, IDLE, REQ).
- Watchdog: `err_timeout` asserts exactly `TIMEOUT` cycles after `ready`.

## Configuration
- `HYDRA_RX_PATTERN_CHK_EN` defined:
  - Payload word i must equal i[15:0].
  - A mismatch sets output `err_data` with `pkt_done` and counts toward `err_cnt`.
  - Output `first_bad_idx` (10 bits) holds the index of the first mismatching word.
- Macro undefined: `err_data` and `first_bad_idx` ports and the comparator are absent; payload contents are ignored.

## Structure
- `hydra_pkg`:
  - header struct typedef (len 9, prio 3, dest 4)
  - FSM state enum
  - width constants `PORT_NUM`=16, `LEN_W`=9
- Sub-module `hydra_rx_watchdog`: a loadable down-counter with clear, start and expired outputs; instantiated once.

## Test plan
- Header {9'd31, 3'd4, 4'd3} + 31 words + eop with `PORT_ID`=3 -> `pkt_done` 1 cycle after eop; `pkt_len`=31, `pkt_prio`=4; no errors; `pkt_cnt`=1, `word_cnt`=31.
- Header length 55, only 54 words sent -> `err_len`=1, `err_cnt`=1; `pkt_cnt` still increments.
- Header dest 5 into `PORT_ID`=3 -> `err_dest`=1.
- No `rd_sop` after `ready`, `TIMEOUT`=16 -> `err_timeout` exactly 16 cycles after `ready`; FSM back to IDLE; next `ready` follows.
- `rd_sop` after 10 payload words, then a full 4-word packet -> `err_proto` sticky; only one `pkt_done`, with `pkt_len`=4 and `err_len`=0.
- With `HYDRA_RX_PATTERN_CHK_EN`: word 7 corrupted in a 128-word packet -> `err_data`=1, `first_bad_idx`=7. Reset asserted mid-packet -> all outputs 0 next cycle.
